// File: rtl/counter_mod_updown_if.sv
//------------------------------------------------------------------------------
// Module      : counter_mod_updown_if
// Description : Control/status bundle for counter_mod_updown.
//               master : drives clr/load/load_val/mod_we/mod_val/en/up/sat,
//                        observes count/carry_out/wrap/at_max/at_min
//               slave  : the counter itself
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface counter_mod_updown_if #(
  parameter int WIDTH = 8
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             mod_we;
  logic [WIDTH-1:0] mod_val;
  logic             en;
  logic             up;
  logic             sat;
  logic [WIDTH-1:0] count;
  logic             carry_out;
  logic             wrap;
  logic             at_max;
  logic             at_min;

  modport master (
    output clr, load, load_val, mod_we, mod_val, en, up, sat,
    input  count, carry_out, wrap, at_max, at_min
  );

  modport slave (
    input  clr, load, load_val, mod_we, mod_val, en, up, sat,
    output count, carry_out, wrap, at_max, at_min
  );
endinterface

`default_nettype wire

// File: rtl/counter_mod_updown.sv
//------------------------------------------------------------------------------
// Module      : counter_mod_updown
// Description : Modulo counter with runtime-programmable modulus, up/down
//               direction, synchronous clear/load, wrap or saturate mode.
//               Cascadable through the combinational carry_out.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous, active-high
//               bus   - counter_mod_updown_if.slave (controls and status)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module counter_mod_updown #(
  parameter int WIDTH   = 8,
  parameter int MOD_RST = 60
) (
  input  wire logic               clk,
  input  wire logic               reset,
  counter_mod_updown_if.slave     bus
);

  localparam logic [WIDTH-1:0] c_mod_rst = WIDTH'(MOD_RST);
  localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);

  logic [WIDTH-1:0] r_mod;
  logic [WIDTH-1:0] r_count;
  logic             r_wrap;

  logic [WIDTH-1:0] w_max;
  logic [WIDTH-1:0] w_count_nx;
  logic             w_wrap_nx;

  // A modulus of 0 stands for the full 2^WIDTH range.
  always_comb begin
    w_max = (r_mod == '0) ? '1 : (r_mod - c_one);
  end

  always_comb begin
    w_count_nx = r_count;
    w_wrap_nx  = 1'b0;
    if (bus.clr) begin
      w_count_nx = '0;
    end else if (bus.load) begin
      w_count_nx = (bus.load_val > w_max) ? w_max : bus.load_val;
    end else if (r_count > w_max) begin
      // Modulus was shrunk under the count: snap back into range.
      w_count_nx = '0;
    end else if (bus.en) begin
      if (bus.up) begin
        if (r_count == w_max) begin
          if (!bus.sat) begin
            w_count_nx = '0;
            w_wrap_nx  = 1'b1;
          end
        end else begin
          w_count_nx = r_count + c_one;
        end
      end else begin
        if (r_count == '0) begin
          if (!bus.sat) begin
            w_count_nx = w_max;
            w_wrap_nx  = 1'b1;
          end
        end else begin
          w_count_nx = r_count - c_one;
        end
      end
    end
  end

  // The count path above reads the current r_mod, so a simultaneous mod_we
  // only affects MAX from the following edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_mod   <= c_mod_rst;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_nx;
      r_wrap  <= w_wrap_nx;
      if (bus.mod_we) begin
        r_mod <= bus.mod_val;
      end
    end
  end

  assign bus.count     = r_count;
  assign bus.wrap      = r_wrap;
  assign bus.at_max    = (r_count == w_max);
  assign bus.at_min    = (r_count == '0);
  assign bus.carry_out = bus.en & ~bus.sat &
                         (bus.up ? (r_count == w_max) : (r_count == '0));

endmodule

`default_nettype wire

// File: tb/tb_counter_mod_updown.sv
//------------------------------------------------------------------------------
// Module      : tb_counter_mod_updown
// Description : Directed self-checking bench for counter_mod_updown: reset,
//               wrap/saturate in both directions, modulus shrink, priority,
//               load clamp, M=1 and full-range moduli, two-stage cascade.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_counter_mod_updown;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  int   lo_wraps;
  int   hi_wraps;

  counter_mod_updown_if #(.WIDTH(8)) if_a  ();
  counter_mod_updown_if #(.WIDTH(8)) if_lo ();
  counter_mod_updown_if #(.WIDTH(8)) if_hi ();

  counter_mod_updown #(.WIDTH(8), .MOD_RST(60)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a.slave)
  );

  counter_mod_updown #(.WIDTH(8), .MOD_RST(10)) u_lo (
    .clk   (clk),
    .reset (reset),
    .bus   (if_lo.slave)
  );

  counter_mod_updown #(.WIDTH(8), .MOD_RST(10)) u_hi (
    .clk   (clk),
    .reset (reset),
    .bus   (if_hi.slave)
  );

  // Cascade: low stage carry enables the high stage.
  assign if_hi.en = if_lo.carry_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass = 0; n_total = 0; lo_wraps = 0; hi_wraps = 0;
    reset = 1'b1;
    if_a.clr = 0; if_a.load = 0; if_a.load_val = 0; if_a.mod_we = 0;
    if_a.mod_val = 0; if_a.en = 0; if_a.up = 1; if_a.sat = 0;
    if_lo.clr = 0; if_lo.load = 0; if_lo.load_val = 0; if_lo.mod_we = 0;
    if_lo.mod_val = 0; if_lo.en = 0; if_lo.up = 1; if_lo.sat = 0;
    if_hi.clr = 0; if_hi.load = 0; if_hi.load_val = 0; if_hi.mod_we = 0;
    if_hi.mod_val = 0; if_hi.up = 1; if_hi.sat = 0;

    repeat (2) step();
    chk("rst_count",  32'(if_a.count),  32'd0);
    chk("rst_at_min", 32'(if_a.at_min), 32'd1);
    chk("rst_at_max", 32'(if_a.at_max), 32'd0);
    chk("rst_wrap",   32'(if_a.wrap),   32'd0);

    // Count up to 37, then reset asynchronously mid-cycle.
    reset = 1'b0;
    if_a.en = 1'b1;
    repeat (37) step();
    chk("cnt37", 32'(if_a.count), 32'd37);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_count",  32'(if_a.count),  32'd0);
    chk("async_rst_at_min", 32'(if_a.at_min), 32'd1);
    chk("async_rst_wrap",   32'(if_a.wrap),   32'd0);
    step();
    reset = 1'b0;

    // Up-wrap at M=60.
    repeat (59) step();
    chk("up59_count",  32'(if_a.count),     32'd59);
    chk("up59_carry",  32'(if_a.carry_out), 32'd1);
    chk("up59_at_max", 32'(if_a.at_max),    32'd1);
    step();
    chk("upwrap_count", 32'(if_a.count), 32'd0);
    chk("upwrap_wrap",  32'(if_a.wrap),  32'd1);
    step();
    chk("post_wrap_count", 32'(if_a.count), 32'd1);
    chk("post_wrap_wrap",  32'(if_a.wrap),  32'd0);

    // Down with saturation from 2.
    if_a.en = 0; if_a.load = 1; if_a.load_val = 8'd2;
    step();
    chk("load2", 32'(if_a.count), 32'd2);
    if_a.load = 0; if_a.up = 0; if_a.sat = 1; if_a.en = 1;
    step();
    chk("dsat_1", 32'(if_a.count), 32'd1);
    step();
    chk("dsat_0", 32'(if_a.count), 32'd0);
    chk("dsat_carry", 32'(if_a.carry_out), 32'd0);
    step();
    chk("dsat_hold_a", 32'(if_a.count), 32'd0);
    step();
    chk("dsat_hold_b", 32'(if_a.count), 32'd0);
    chk("dsat_wrap",   32'(if_a.wrap),  32'd0);

    // Same point, wrap mode: down-wrap to MAX.
    if_a.sat = 0;
    #1;
    chk("dwrap_carry", 32'(if_a.carry_out), 32'd1);
    step();
    chk("dwrap_count", 32'(if_a.count), 32'd59);
    chk("dwrap_wrap",  32'(if_a.wrap),  32'd1);

    // Modulus shrink under count=45.
    if_a.en = 0; if_a.up = 1; if_a.load = 1; if_a.load_val = 8'd45;
    step();
    if_a.load = 0; if_a.mod_we = 1; if_a.mod_val = 8'd10;
    step();
    chk("shrink_hold", 32'(if_a.count),  32'd45);
    chk("shrink_atmax", 32'(if_a.at_max), 32'd0);
    if_a.mod_we = 0;
    step();
    chk("shrink_count", 32'(if_a.count), 32'd0);
    chk("shrink_wrap",  32'(if_a.wrap),  32'd0);
    if_a.en = 1;
    repeat (9) step();
    chk("m10_count9", 32'(if_a.count), 32'd9);
    step();
    chk("m10_wrap_count", 32'(if_a.count), 32'd0);
    chk("m10_wrap",       32'(if_a.wrap),  32'd1);

    // Up saturation holds at MAX.
    if_a.en = 0; if_a.load = 1; if_a.load_val = 8'd9;
    step();
    if_a.load = 0; if_a.en = 1; if_a.sat = 1;
    step();
    chk("usat_hold", 32'(if_a.count), 32'd9);
    chk("usat_wrap", 32'(if_a.wrap),  32'd0);

    // Priority: clr beats load and en.
    if_a.sat = 0; if_a.clr = 1; if_a.load = 1; if_a.load_val = 8'd5;
    step();
    chk("prio_clr", 32'(if_a.count), 32'd0);
    if_a.clr = 0; if_a.load = 0; if_a.en = 0;

    // Back to M=60, load clamp.
    if_a.mod_we = 1; if_a.mod_val = 8'd60;
    step();
    if_a.mod_we = 0; if_a.load = 1; if_a.load_val = 8'd200;
    step();
    chk("load_clamp", 32'(if_a.count), 32'd59);
    if_a.load = 0;

    // M=1: count pinned at 0, wrap every enabled edge.
    if_a.mod_we = 1; if_a.mod_val = 8'd1;
    step();
    if_a.mod_we = 0;
    step();
    chk("m1_snap", 32'(if_a.count), 32'd0);
    if_a.en = 1;
    step();
    chk("m1_wrap_a", 32'(if_a.wrap), 32'd1);
    step();
    chk("m1_wrap_b",  32'(if_a.wrap),   32'd1);
    chk("m1_count",   32'(if_a.count),  32'd0);
    chk("m1_at_max",  32'(if_a.at_max), 32'd1);

    // Full range (M=0): 255 wraps to 0.
    if_a.en = 0; if_a.mod_we = 1; if_a.mod_val = 8'd0;
    step();
    if_a.mod_we = 0; if_a.load = 1; if_a.load_val = 8'd255;
    step();
    chk("full_load255", 32'(if_a.count), 32'd255);
    if_a.load = 0; if_a.en = 1;
    step();
    chk("full_wrap_count", 32'(if_a.count), 32'd0);
    chk("full_wrap",       32'(if_a.wrap),  32'd1);
    if_a.en = 0;

    // Cascade of two M=10 stages.
    if_lo.en = 1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (if_lo.wrap) lo_wraps++;
      if (if_hi.wrap) hi_wraps++;
      if (i == 55) begin
        chk("casc55_lo", 32'(if_lo.count), 32'd5);
        chk("casc55_hi", 32'(if_hi.count), 32'd5);
      end
    end
    if_lo.en = 0;
    chk("casc_lo",       32'(if_lo.count), 32'd0);
    chk("casc_hi",       32'(if_hi.count), 32'd0);
    chk("casc_hi_wraps", 32'(hi_wraps),    32'd1);
    chk("casc_lo_wraps", 32'(lo_wraps),    32'd10);
    chk("casc_hi_wrap_last", 32'(if_hi.wrap), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
